move_input_ctrl: RTL and testbench

- Upstream front end of the 2048 game controller.
- Conditions the four raw board push-buttons: polarity normalisation, 2-flop synchronisation, per-button debounce and press-edge detection.
- Fixed-priority arbitration reduces all key activity to one move at a time.
- Each move is presented through a valid/ready handshake that feeds the game FSM's move_up/move_down/move_left/move_right inputs.

---
 rtl/move_input_ctrl.sv | 137 +++++++++++++
 tb/tb_move_input_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_input_ctrl.sv
// Button front end for the 2048 controller: synchronises and debounces the four
// push-buttons, arbitrates press edges and presents one move at a time on valid/ready.
module move_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       move_ready,
    output logic       move_valid,
    output logic       move_up,
    output logic       move_down,
    output logic       move_left,
    output logic       move_right,
    output logic [3:0] key_stable
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        LOCKED
    } state_t;

    logic [3:0]    rawPressed;
    logic [3:0]    sync1_q;
    logic [3:0]    sync2_q;
    logic [CW-1:0] cnt_q [4];
    logic [3:0]    stable_q;
    logic [3:0]    prevStable_q;
    logic [3:0]    pressEvent;
    logic [3:0]    winner;
    state_t        state_q;
    logic          valid_q;
    logic [3:0]    code_q;

    // Bit order everywhere: 3 up, 2 down, 1 left, 0 right; 1 means pressed.
    assign rawPressed = {btn_up, btn_down, btn_left, btn_right} ^ {4{ACTIVE_LOW}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
        end else begin
            sync1_q <= rawPressed;
            sync2_q <= sync1_q;
        end
    end

    // The stable level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q     <= 4'b0000;
            prevStable_q <= 4'b0000;
        end else begin
            prevStable_q <= stable_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    stable_q[i] <= ~stable_q[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign pressEvent = stable_q & ~prevStable_q;

    always_comb begin
        winner = 4'b0000;
        if (pressEvent[3]) begin
            winner = 4'b1000;
        end else if (pressEvent[2]) begin
            winner = 4'b0100;
        end else if (pressEvent[1]) begin
            winner = 4'b0010;
        end else if (pressEvent[0]) begin
            winner = 4'b0001;
        end
    end

    // LOCKED waits for every key to be released so a held key never repeats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            code_q  <= 4'b0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pressEvent != 4'b0000) begin
                        state_q <= PENDING;
                        valid_q <= 1'b1;
                        code_q  <= winner;
                    end
                end
                PENDING: begin
                    if (move_ready) begin
                        state_q <= LOCKED;
                        valid_q <= 1'b0;
                        code_q  <= 4'b0000;
                    end
                end
                LOCKED: begin
                    if (stable_q == 4'b0000) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    code_q  <= 4'b0000;
                end
            endcase
        end
    end

    assign move_valid = valid_q;
    assign move_up    = code_q[3];
    assign move_down  = code_q[2];
    assign move_left  = code_q[1];
    assign move_right = code_q[0];
    assign key_stable = stable_q;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Randomised bench for move_input_ctrl against a cycle-level behavioural model of
// debounce, press arbitration and the one-move-per-press handshake.
module tb_move_input_ctrl;

    localparam int DEB = 4;
    localparam bit AL  = 1'b1;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] pressedVec;
    logic       moveReady;
    logic       btnUp, btnDown, btnLeft, btnRight;
    logic       moveValid, moveUp, moveDown, moveLeft, moveRight;
    logic [3:0] keyStable;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] pressHist [$];
    logic [3:0] pendingQ [$];
    logic [3:0] mStable;
    logic [3:0] mPrev;
    int         runLen [4];
    bit         mLocked;

    assign btnUp    = pressedVec[3] ^ AL;
    assign btnDown  = pressedVec[2] ^ AL;
    assign btnLeft  = pressedVec[1] ^ AL;
    assign btnRight = pressedVec[0] ^ AL;

    move_input_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .ACTIVE_LOW     (AL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btnUp),
        .btn_down  (btnDown),
        .btn_left  (btnLeft),
        .btn_right (btnRight),
        .move_ready(moveReady),
        .move_valid(moveValid),
        .move_up   (moveUp),
        .move_down (moveDown),
        .move_left (moveLeft),
        .move_right(moveRight),
        .key_stable(keyStable)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [3:0] highestPress(input logic [3:0] v);
        logic [3:0] r;
        r = 4'b0000;
        for (int b = 3; b >= 0; b--) begin
            if (v[b] && r == 4'b0000) r[b] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [4:0] expMove();
        if (pendingQ.size() > 0) return {1'b1, pendingQ[0]};
        return 5'b00000;
    endfunction

    task automatic modelReset();
        pressHist.delete();
        pendingQ.delete();
        mStable = 4'b0000;
        mPrev   = 4'b0000;
        mLocked = 1'b0;
        for (int i = 0; i < 4; i++) runLen[i] = 0;
    endtask

    // Each key's debounced level is the pressed level seen two edges earlier,
    // accepted only once it has disagreed for DEB edges in a row.
    task automatic modelEdge();
        logic [3:0] seen;
        logic [3:0] ev;
        seen = (pressHist.size() >= 2) ? pressHist[pressHist.size() - 2] : 4'b0000;
        ev   = mStable & ~mPrev;
        if (pendingQ.size() > 0) begin
            if (moveReady) begin
                void'(pendingQ.pop_front());
                mLocked = 1'b1;
            end
        end else if (mLocked) begin
            if (mStable == 4'b0000) mLocked = 1'b0;
        end else if (ev != 4'b0000) begin
            pendingQ.push_back(highestPress(ev));
        end
        mPrev = mStable;
        for (int i = 0; i < 4; i++) begin
            if (seen[i] != mStable[i]) begin
                runLen[i]++;
                if (runLen[i] == DEB) begin
                    mStable[i] = ~mStable[i];
                    runLen[i]  = 0;
                end
            end else begin
                runLen[i] = 0;
            end
        end
        pressHist.push_back(pressedVec);
        if (pressHist.size() > 4) void'(pressHist.pop_front());
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        if (!reset) modelEdge();
        #1;
        checkOutput("keyStable", {28'd0, keyStable}, {28'd0, mStable});
        checkOutput("move", {27'd0, moveValid, moveUp, moveDown, moveLeft, moveRight}, {27'd0, expMove()});
    endtask

    task automatic stepN(input int n);
        for (int k = 0; k < n; k++) applyStimulus();
    endtask

    function automatic logic [4:0] dutMove();
        return {moveValid, moveUp, moveDown, moveLeft, moveRight};
    endfunction

    initial begin
        int holdT [4];
        int readyT;
        reset      = 1'b1;
        pressedVec = 4'b0000;
        moveReady  = 1'b1;
        modelReset();
        #1;
        checkOutput("resetMove", {27'd0, dutMove()}, 32'd0);
        checkOutput("resetKeys", {28'd0, keyStable}, 32'd0);
        stepN(2);
        reset = 1'b0;
        stepN(4);

        // Clean press of up: stable after edge 5, single move after edge 6.
        pressedVec = 4'b1000;
        for (int e = 0; e <= 7; e++) begin
            applyStimulus();
            if (e == 4) checkOutput("cleanKs4", {28'd0, keyStable}, 32'h0);
            if (e == 5) checkOutput("cleanKs5", {28'd0, keyStable}, 32'h8);
            if (e == 5) checkOutput("cleanMv5", {27'd0, dutMove()}, 32'h00);
            if (e == 6) checkOutput("cleanMv6", {27'd0, dutMove()}, 32'h18);
            if (e == 7) checkOutput("cleanMv7", {27'd0, dutMove()}, 32'h00);
        end
        stepN(10);
        checkOutput("heldNoRepeat", {27'd0, dutMove()}, 32'h00);
        pressedVec = 4'b0000;
        stepN(7);
        checkOutput("releaseKs", {28'd0, keyStable}, 32'h0);
        stepN(3);

        // Bounce on left never reaches the debounce threshold.
        pressedVec = 4'b0010; stepN(3);
        pressedVec = 4'b0000; stepN(1);
        pressedVec = 4'b0010; stepN(3);
        pressedVec = 4'b0000; stepN(8);
        checkOutput("bounceKs", {28'd0, keyStable}, 32'h0);

        // Simultaneous down and right: down wins.
        pressedVec = 4'b0101;
        stepN(7);
        checkOutput("simulMv", {27'd0, dutMove()}, 32'h14);
        stepN(3);
        pressedVec = 4'b0001;
        stepN(10);
        pressedVec = 4'b0000;
        stepN(10);

        // Backpressure holds the right move while up comes and goes.
        moveReady  = 1'b0;
        pressedVec = 4'b0001;
        stepN(7);
        for (int c = 0; c < 20; c++) begin
            if (c == 2)  pressedVec = 4'b1001;
            if (c == 11) pressedVec = 4'b0001;
            applyStimulus();
            checkOutput("bpHold", {27'd0, dutMove()}, 32'h11);
        end
        moveReady = 1'b1;
        applyStimulus();
        checkOutput("bpXfer", {27'd0, dutMove()}, 32'h00);
        pressedVec = 4'b0000;
        stepN(10);

        // Reset while pending, with left still held afterwards.
        moveReady  = 1'b0;
        pressedVec = 4'b0010;
        stepN(7);
        checkOutput("rpPending", {27'd0, dutMove()}, 32'h12);
        reset = 1'b1;
        #1;
        checkOutput("rpAsync", {27'd0, dutMove()}, 32'h00);
        modelReset();
        stepN(2);
        reset = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            applyStimulus();
            if (e == 5) checkOutput("rpMv5", {27'd0, dutMove()}, 32'h00);
            if (e == 6) checkOutput("rpMv6", {27'd0, dutMove()}, 32'h12);
        end
        moveReady  = 1'b1;
        pressedVec = 4'b0000;
        stepN(10);

        // Repeat presses: a full release gives a second move, a short gap does not.
        pressedVec = 4'b1000; stepN(10);
        pressedVec = 4'b0000; stepN(10);
        pressedVec = 4'b1000; stepN(10);
        pressedVec = 4'b0000; stepN(3);
        pressedVec = 4'b1000; stepN(10);
        pressedVec = 4'b0000; stepN(10);

        // Random phase.
        for (int i = 0; i < 4; i++) holdT[i] = $urandom_range(5, 40);
        readyT = $urandom_range(5, 30);
        for (int c = 0; c < 5000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (holdT[i] == 0) begin
                    pressedVec[i] = ~pressedVec[i];
                    if ($urandom_range(0, 1) == 0) holdT[i] = $urandom_range(1, 3);
                    else if (pressedVec[i])        holdT[i] = $urandom_range(4, 25);
                    else                           holdT[i] = $urandom_range(10, 60);
                end else begin
                    holdT[i]--;
                end
            end
            if (readyT == 0) begin
                moveReady = ~moveReady;
                readyT    = moveReady ? $urandom_range(1, 30) : $urandom_range(1, 10);
            end else begin
                readyT--;
            end
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b1;
                #1;
                checkOutput("rndRstMove", {27'd0, dutMove()}, 32'h00);
                checkOutput("rndRstKeys", {28'd0, keyStable}, 32'h0);
                modelReset();
                applyStimulus();
                reset = 1'b0;
            end
            applyStimulus();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
